// File: rtl/uart_frame_pkg.sv
// Shared types, default frame bytes and baud helper for the status-frame receiver.
package uart_frame_pkg;

    // Frame-level state: waiting for header, three payload bytes, trailer.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_C2    = 3'd1,
        ST_C1    = 3'd2,
        ST_C0    = 3'd3,
        ST_TRAIL = 3'd4
    } frame_state_t;

    // Bit-level receiver state.
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam logic [7:0] DEF_HEADER  = 8'h22;
    localparam logic [7:0] DEF_TRAILER = 8'h55;

    // Clock cycles per UART bit, truncated.
    function automatic int bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop check.
module uart_rx_byte
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RsRx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_ferr
);

    localparam int BIT_CYC  = bit_cyc(CLK_FREQ, BAUD);
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic            sync1_r;
    logic            sync2_r;
    rx_state_t       rx_state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic [7:0]      byte_data_r;
    logic            byte_valid_r;
    logic            byte_ferr_r;

    // Two-flop synchronizer on the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= RsRx;
            sync2_r <= sync1_r;
        end
    end

    // Bit-timing state machine; idle is only entered with the line high,
    // so a low level seen while idle is the falling edge of a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r   <= RX_IDLE;
            cnt_r        <= CNT_ZERO;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_data_r  <= 8'h00;
            byte_valid_r <= 1'b0;
            byte_ferr_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            byte_ferr_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    cnt_r     <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                    if (!sync2_r) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_END) begin
                        cnt_r <= CNT_ZERO;
                        // Still low at mid start bit: real start, else a glitch.
                        if (!sync2_r) begin
                            rx_state_r <= RX_DATA;
                        end else begin
                            rx_state_r <= RX_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == BIT_END) begin
                        cnt_r   <= CNT_ZERO;
                        shift_r <= {sync2_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == BIT_END) begin
                        cnt_r <= CNT_ZERO;
                        if (sync2_r) begin
                            byte_data_r  <= shift_r;
                            byte_valid_r <= 1'b1;
                            rx_state_r   <= RX_IDLE;
                        end else begin
                            byte_ferr_r <= 1'b1;
                            rx_state_r  <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    // Bad stop bit: hold off until the line returns high.
                    if (sync2_r) begin
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_state_r <= RX_WAIT_HIGH;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    assign byte_data  = byte_data_r;
    assign byte_valid = byte_valid_r;
    assign byte_ferr  = byte_ferr_r;

endmodule

// File: rtl/uart_frame_recv.sv
// Receives {HEADER, char2, char1, char0, TRAILER} and publishes the payload.
module uart_frame_recv
    import uart_frame_pkg::*;
#(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter int         BAUD        = 115_200,
    parameter logic [7:0] HEADER      = uart_frame_pkg::DEF_HEADER,
    parameter logic [7:0] TRAILER     = uart_frame_pkg::DEF_TRAILER,
    parameter int         TIMEOUT_CYC = 20 * uart_frame_pkg::bit_cyc(CLK_FREQ, BAUD)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RsRx,
    output logic [23:0] recv_str,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [7:0]       byte_data_s;
    logic             byte_valid_s;
    logic             byte_ferr_s;
    logic             timeout_s;
    frame_state_t     state_r;
    logic [23:0]      shadow_r;
    logic [23:0]      recv_str_r;
    logic             frame_valid_r;
    logic             frame_err_r;
    logic             busy_r;
    logic [TMR_W-1:0] timer_r;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .RsRx       (RsRx),
        .byte_data  (byte_data_s),
        .byte_valid (byte_valid_s),
        .byte_ferr  (byte_ferr_s)
    );

    assign timeout_s = (timer_r == TMR_MAX);

    // Inter-byte gap timer: restarts on each byte, saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= TMR_ZERO;
        end else if ((state_r == ST_IDLE) || byte_valid_s) begin
            timer_r <= TMR_ZERO;
        end else if (timer_r != TMR_MAX) begin
            timer_r <= timer_r + TMR_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Frame FSM with payload shadow, published payload and status strobes.
    // A byte arriving in the same cycle as the timeout wins over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            shadow_r      <= 24'h000000;
            recv_str_r    <= 24'h000000;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (byte_valid_s && (byte_data_s == HEADER)) begin
                        state_r <= ST_C2;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_C2, ST_C1, ST_C0: begin
                    if (byte_ferr_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                    end else if (byte_valid_s) begin
                        if (state_r == ST_C2) begin
                            shadow_r[23:16] <= byte_data_s;
                            state_r         <= ST_C1;
                        end else if (state_r == ST_C1) begin
                            shadow_r[15:8] <= byte_data_s;
                            state_r        <= ST_C0;
                        end else begin
                            shadow_r[7:0] <= byte_data_s;
                            state_r       <= ST_TRAIL;
                        end
                    end else if (timeout_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_TRAIL: begin
                    if (byte_ferr_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                    end else if (byte_valid_s) begin
                        // A wrong trailer is not re-examined as a new header.
                        if (byte_data_s == TRAILER) begin
                            recv_str_r    <= shadow_r;
                            frame_valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (timeout_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_TRAIL;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign recv_str    = recv_str_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign busy        = busy_r;

endmodule
